// File: rtl/fifo_ptr_ctrl_if.sv
// rtl/fifo_ptr_ctrl_if.sv - request, RAM-control and status bundle for fifo_ptr_ctrl
interface fifo_ptr_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              clr;
  logic              wr_req;
  logic              rd_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_raddr;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   wr_ptr_gray;
  logic [ADDR_W:0]   rd_ptr_gray;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_req, rd_req,
    input  ram_we, ram_waddr, ram_re, ram_raddr, rd_valid,
    input  full, empty, almost_full, almost_empty, count,
    input  wr_ptr_gray, rd_ptr_gray, overflow, underflow
  );

  modport slave (
    input  clr, wr_req, rd_req,
    output ram_we, ram_waddr, ram_re, ram_raddr, rd_valid,
    output full, empty, almost_full, almost_empty, count,
    output wr_ptr_gray, rd_ptr_gray, overflow, underflow
  );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - FIFO pointer, flag and RAM-control logic for an external sync-read RAM
module fifo_ptr_ctrl #(
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4
) (
  input  logic           clk,
  input  logic           rst,
  fifo_ptr_ctrl_if.slave bus
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT = PW'(AE_LEVEL);

  logic [PW-1:0] wr_bin, rd_bin;
  logic [PW-1:0] wr_gray, rd_gray;
  logic [PW-1:0] wr_bin_nxt, rd_bin_nxt;
  logic [PW-1:0] cnt;
  logic          full_i, empty_i;
  logic          wr_acc, rd_acc;
  logic          rd_valid_q, ovf_q, unf_q;

  // Flags come from the registered Gray pointers so they settle with the reset
  assign empty_i = (wr_gray == rd_gray);
  assign full_i  = (wr_gray == {~rd_gray[PW-1:PW-2], rd_gray[PW-3:0]});

  assign wr_acc     = bus.wr_req & ~full_i  & ~bus.clr;
  assign rd_acc     = bus.rd_req & ~empty_i & ~bus.clr;
  assign wr_bin_nxt = wr_bin + 1'b1;
  assign rd_bin_nxt = rd_bin + 1'b1;
  assign cnt        = wr_bin - rd_bin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bin     <= '0;
      rd_bin     <= '0;
      wr_gray    <= '0;
      rd_gray    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else if (bus.clr) begin
      wr_bin     <= '0;
      rd_bin     <= '0;
      wr_gray    <= '0;
      rd_gray    <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_bin  <= wr_bin_nxt;
        wr_gray <= wr_bin_nxt ^ (wr_bin_nxt >> 1);
      end
      if (rd_acc) begin
        rd_bin  <= rd_bin_nxt;
        rd_gray <= rd_bin_nxt ^ (rd_bin_nxt >> 1);
      end
      rd_valid_q <= rd_acc;
      if (bus.wr_req && full_i)  ovf_q <= 1'b1;
      if (bus.rd_req && empty_i) unf_q <= 1'b1;
    end
  end

  assign bus.ram_we       = wr_acc;
  assign bus.ram_re       = rd_acc;
  assign bus.ram_waddr    = wr_bin[ADDR_W-1:0];
  assign bus.ram_raddr    = rd_bin[ADDR_W-1:0];
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.almost_full  = (cnt >= AF_CNT);
  assign bus.almost_empty = (cnt <= AE_CNT);
  assign bus.count        = cnt;
  assign bus.wr_ptr_gray  = wr_gray;
  assign bus.rd_ptr_gray  = rd_gray;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb/tb_fifo_ptr_ctrl.sv - directed vector and sequence bench for fifo_ptr_ctrl
module tb_fifo_ptr_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_ptr_ctrl_if #(.ADDR_W(4)) bus ();

  fifo_ptr_ctrl #(.ADDR_W(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic  wr, rd, clr;
    logic  we, re;
    int    cnt;
    logic  full, empty, ovf, unf, rdv;
    string nm;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int failures = 0;

  // bench reference model
  logic [4:0] m_wr = '0, m_rd = '0;
  logic       m_ovf = 0, m_unf = 0, m_rdv = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic c);
    bus.wr_req = w;
    bus.rd_req = r;
    bus.clr    = c;
  endtask

  task automatic check_state(input string tag);
    logic [4:0] c;
    c = m_wr - m_rd;
    chk({tag, "_count"}, 32'(bus.count), 32'(c));
    chk({tag, "_full"}, 32'(bus.full), 32'(c == 5'd16));
    chk({tag, "_empty"}, 32'(bus.empty), 32'(c == 5'd0));
    chk({tag, "_afull"}, 32'(bus.almost_full), 32'(c >= 5'd12));
    chk({tag, "_aempty"}, 32'(bus.almost_empty), 32'(c <= 5'd4));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(bus.underflow), 32'(m_unf));
    chk({tag, "_rdv"}, 32'(bus.rd_valid), 32'(m_rdv));
    chk({tag, "_wgray"}, 32'(bus.wr_ptr_gray), 32'(m_wr ^ (m_wr >> 1)));
    chk({tag, "_rgray"}, 32'(bus.rd_ptr_gray), 32'(m_rd ^ (m_rd >> 1)));
  endtask

  // one clocked operation: comb outputs checked mid-cycle, state checked after the edge
  task automatic op(input logic w, input logic r, input logic c, input string tag);
    logic [4:0] cn;
    logic ew, er, fm, em;
    logic [4:0] pwg, prg;
    cn = m_wr - m_rd;
    fm = (cn == 5'd16);
    em = (cn == 5'd0);
    ew = w & ~fm & ~c;
    er = r & ~em & ~c;
    pwg = bus.wr_ptr_gray;
    prg = bus.rd_ptr_gray;
    drive(w, r, c);
    @(negedge clk);
    chk({tag, "_we"}, 32'(bus.ram_we), 32'(ew));
    chk({tag, "_re"}, 32'(bus.ram_re), 32'(er));
    chk({tag, "_waddr"}, 32'(bus.ram_waddr), 32'(m_wr[3:0]));
    chk({tag, "_raddr"}, 32'(bus.ram_raddr), 32'(m_rd[3:0]));
    @(posedge clk);
    #1;
    if (c) begin
      m_wr = '0; m_rd = '0; m_ovf = 0; m_unf = 0; m_rdv = 0;
    end else begin
      if (w && fm) m_ovf = 1;
      if (r && em) m_unf = 1;
      if (ew) m_wr = m_wr + 5'd1;
      if (er) m_rd = m_rd + 5'd1;
      m_rdv = er;
      if (ew) chk({tag, "_wgray_1bit"}, 32'($countones(pwg ^ bus.wr_ptr_gray)), 32'd1);
      if (er) chk({tag, "_rgray_1bit"}, 32'($countones(prg ^ bus.rd_ptr_gray)), 32'd1);
    end
    check_state(tag);
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "v_rd_empty"};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "v_wr"};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "v_wr_rd"};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "v_rd"};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "v_clr_pri"};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "v_wr2"};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "v_clr"};

    drive(0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].clr);
      @(negedge clk);
      chk({vecs[i].nm, "_we"}, 32'(bus.ram_we), 32'(vecs[i].we));
      chk({vecs[i].nm, "_re"}, 32'(bus.ram_re), 32'(vecs[i].re));
      @(posedge clk);
      #1;
      chk({vecs[i].nm, "_count"}, 32'(bus.count), 32'(vecs[i].cnt));
      chk({vecs[i].nm, "_full"}, 32'(bus.full), 32'(vecs[i].full));
      chk({vecs[i].nm, "_empty"}, 32'(bus.empty), 32'(vecs[i].empty));
      chk({vecs[i].nm, "_ovf"}, 32'(bus.overflow), 32'(vecs[i].ovf));
      chk({vecs[i].nm, "_unf"}, 32'(bus.underflow), 32'(vecs[i].unf));
      chk({vecs[i].nm, "_rdv"}, 32'(bus.rd_valid), 32'(vecs[i].rdv));
    end

    for (int i = 0; i < 16; i++) op(1, 0, 0, "fill");
    chk("fill_wgray_11000", 32'(bus.wr_ptr_gray), 32'h18);
    chk("fill_count16", 32'(bus.count), 32'd16);
    op(1, 0, 0, "wr_full");
    op(1, 1, 0, "wr_rd_full");
    op(0, 0, 1, "clr_after_ovf");

    op(0, 1, 0, "rd_empty");
    op(0, 0, 0, "rd_empty_idle");
    op(0, 0, 1, "clr_after_unf");

    for (int i = 0; i < 8; i++) op(1, 0, 0, "to8");
    op(1, 1, 0, "simul8");
    op(0, 0, 0, "simul8_next");

    for (int i = 0; i < 40; i++) begin
      case (i % 4)
        0, 3:    op(1, 1, 0, "wrap_both");
        1:       op(1, 0, 0, "wrap_wr");
        default: op(0, 1, 0, "wrap_rd");
      endcase
    end

    for (int i = 0; i < 3; i++) op(1, 0, 0, "to11");
    op(0, 1, 0, "rd_inflight");
    drive(0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    m_wr = '0; m_rd = '0; m_ovf = 0; m_unf = 0; m_rdv = 0;
    check_state("async_rst");
    chk("async_rst_waddr", 32'(bus.ram_waddr), 32'd0);
    chk("async_rst_raddr", 32'(bus.ram_raddr), 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_state("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_ptr_ctrl.md
FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, giving the RAM address width (depth = 2^ADDR_W); legal range is ADDR_W >= 2.
REQ-002 The block SHALL have parameter AF_LEVEL, default 12: almost_full asserts when count >= AF_LEVEL.
REQ-003 The block SHALL have parameter AE_LEVEL, default 4: almost_empty asserts when count <= AE_LEVEL; legal range is 0 < AE_LEVEL < AF_LEVEL < 2^ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port clr, input, 1 bit: synchronous clear, active-high.
REQ-007 The block SHALL have port wr_req, input, 1 bit: write request.
REQ-008 The block SHALL have port rd_req, input, 1 bit: read request.
REQ-009 The block SHALL have port ram_we, output, 1 bit: RAM write enable.
REQ-010 The block SHALL have port ram_waddr, output, ADDR_W bits: RAM write address.
REQ-011 The block SHALL have port ram_re, output, 1 bit: RAM read enable (RAM has synchronous read, 1-cycle latency).
REQ-012 The block SHALL have port ram_raddr, output, ADDR_W bits: RAM read address.
REQ-013 The block SHALL have port rd_valid, output, 1 bit: RAM read data valid this cycle.
REQ-014 The block SHALL have ports full, empty, almost_full and almost_empty, outputs, 1 bit each: status flags.
REQ-015 The block SHALL have port count, output, ADDR_W+1 bits: current occupancy, 0..2^ADDR_W.
REQ-016 The block SHALL have ports wr_ptr_gray and rd_ptr_gray, outputs, ADDR_W+1 bits each: Gray-coded pointers.
REQ-017 The block SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.

Function
REQ-018 Pointers SHALL be (ADDR_W+1)-bit binary counters that wrap from 2^(ADDR_W+1)-1 to 0; Gray value = bin ^ (bin >> 1), held in registers.
REQ-019 Write acceptance: wr_acc = wr_req & ~full & ~clr; read acceptance: rd_acc = rd_req & ~empty & ~clr; both use flags from registered pointers of the current cycle.
REQ-020 ram_we SHALL equal wr_acc and ram_re SHALL equal rd_acc, combinationally, in the same cycle as the request.
REQ-021 ram_waddr and ram_raddr SHALL be the low ADDR_W bits of the binary write and read pointers.
REQ-022 On wr_acc the write pointer SHALL increment at the next edge; on rd_acc the read pointer SHALL increment at the next edge.
REQ-023 rd_valid SHALL be registered rd_acc, i.e. high exactly one cycle after each accepted read.
REQ-024 empty SHALL be 1 iff wr_ptr_gray == rd_ptr_gray.
REQ-025 full SHALL be 1 iff wr_ptr_gray equals rd_ptr_gray with its two MSBs inverted.
REQ-026 count SHALL equal (wr_bin - rd_bin) mod 2^(ADDR_W+1); a simultaneous accepted read and write leaves count unchanged.
REQ-027 Simultaneous events: when full, a read is accepted and a write is rejected; when empty, a write is accepted and a read is rejected; otherwise both are accepted.
REQ-028 wr_req & full & ~clr SHALL set overflow; rd_req & empty & ~clr SHALL set underflow; both flags hold until clr or reset.
REQ-029 clr SHALL have priority over requests: the next edge zeroes pointers, clears overflow/underflow and rd_valid, and leaves ram_we = ram_re = 0 during the clr cycle.
REQ-030 Each Gray pointer SHALL change by exactly one bit per increment, including at the wrap.

Reset
REQ-031 While rst = 0, the block SHALL immediately, without a clock edge, drive pointers, count, ram addresses, rd_valid, full, almost_full, overflow and underflow to 0, and empty and almost_empty to 1.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight reads: rd_valid = 0 on the first cycle after release.

Verification (ADDR_W = 4, default levels)
REQ-033 Reset, then 16 consecutive writes -> full = 1, count = 16, wr_ptr_gray = 5'b11000, almost_full asserted from count = 12.
REQ-034 17th write while full -> ram_we = 0, overflow = 1, count stays 16; then clr -> count = 0, empty = 1, overflow = 0.
REQ-035 rd_req while empty -> ram_re = 0, underflow = 1, rd_valid stays 0.
REQ-036 At count = 8, wr_req = rd_req = 1 for one cycle -> ram_we = ram_re = 1, count stays 8, both pointers advance, rd_valid = 1 on the next cycle.
REQ-037 40 interleaved writes and reads crossing pointer wrap 31 -> 0 -> each Gray pointer changes exactly one bit per increment, and count always matches the scoreboard.
REQ-038 rst pulsed low asynchronously at count = 10 with a read in flight -> outputs take reset values before the next edge, and rd_valid = 0 after release.
